// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding, idle address.
// Also holds the request legality check used at accept time.
package lsu_dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] IDLE_ADDR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_t;

  // Misaligned halfword/word, unknown funct3, or unsigned-width store.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = (lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension, and store merge into a read word.
// Purely combinational; no state, no handshake.
module lsu_lane_align
  import lsu_dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    load_data = rword;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rword;
    endcase

    // Only the addressed lane is replaced; the rest comes from memory.
    store_word = rword;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = sdata[7:0];
          2'd1:    store_word[15:8]  = sdata[7:0];
          2'd2:    store_word[23:16] = sdata[7:0];
          default: store_word[31:24] = sdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = sdata[15:0];
        else            store_word[15:0]  = sdata[15:0];
      end
      default: store_word = sdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// One request in flight; loads respond after 1+MEM_RD_LAT cycles, SW after 2, SB/SH after 2+MEM_RD_LAT.
module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int          MEM_RD_LAT = 1,   // legal 1..4
  parameter logic [31:0] IDLE_ADDR  = IDLE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wen_D,
  output logic [31:0] mem_addr_D,
  output logic [31:0] mem_wdata_D,
  input  logic [31:0] mem_rdata_D
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        illegal;
  logic        rd_last;
  logic [31:0] word_addr;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept     = req_valid & req_ready;
  assign illegal    = req_illegal(req_we, req_funct3, req_addr[1:0]);
  assign rd_last    = (cnt_q == LAT_LAST);
  assign word_addr  = {addr_q[31:2], 2'b00};
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .rword      (mem_rdata_D),
    .sdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wen_D   = 1'b0;
    mem_addr_D  = IDLE_ADDR;
    mem_wdata_D = 32'h0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          if (illegal)                           state_d = ST_RESP;
          else if (req_we && req_funct3 == F3_W) state_d = ST_WR;
          else                                   state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        mem_addr_D = word_addr;
        if (rd_last) state_d = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_wen_D   = rst_n;
        mem_addr_D  = word_addr;
        mem_wdata_D = wdata_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = rst_n;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset is synchronous, so the memory pins are forced quiet for the whole reset cycle.
    if (!rst_n) begin
      mem_addr_D  = IDLE_ADDR;
      mem_wdata_D = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= 3'd0;
        if (illegal) begin
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b1;
        end
      end
      if (state_q == ST_RD_WAIT) begin
        if (!rd_last) begin
          cnt_q <= cnt_q + 3'd1;
        end else if (we_q) begin
          wdata_q <= store_word;
        end else begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
        end
      end
      if (state_q == ST_WR) begin
        resp_rdata_q <= 32'h0;
        resp_err_q   <= 1'b0;
      end
    end
  end

endmodule
